// File: rtl/mac_pkg.sv
// Shared types for the MAC result drain: serializer state encoding and default result width.
package mac_pkg;

   localparam int MAC_DATA_W = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LANE0 = 2'b01,
      LANE1 = 2'b10
   } ser_state_e;

endpackage

// File: rtl/mac_result_drain_pair_fifo.sv
// Synchronous FIFO of W-bit entries; a push while full is taken only alongside a pop.
// Exposes the head and the entry behind it so the consumer can chain pops without a bubble.
module pair_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             head_o,
   output logic [W-1:0]             head_nxt_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign rd_en      = pop_i & ~empty_o;
   assign wr_en      = push_i & (~full_o | rd_en);
   assign rd_nxt     = rd_ptr_q + AW'(1);
   assign head_o     = mem_q[rd_ptr_q];
   assign head_nxt_o = mem_q[rd_nxt];

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_nxt : rd_ptr_q;
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the pointers and count define which slots are live.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mac_result_drain.sv
// Captures lane-0/1 accumulator pairs on the joint clear edge, queues them, and streams them lane 0 first.
// Output is valid one cycle after the pair lands in the FIFO; words hold stable under res_ready_i backpressure.
module mac_result_drain
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] acc_0_i,
   input  logic [DATA_W-1:0] acc_1_i,
   input  logic              clear_local_0_i,
   input  logic              clear_local_1_i,
   input  logic              done_i,
   output logic [DATA_W-1:0] res_data_o,
   output logic              res_lane_o,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic              overflow_o,
   output logic              busy_o,
   output logic              drain_done_o
);

   localparam int PW = 2 * DATA_W;
   localparam int CW = $clog2(DEPTH) + 1;

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d, hold_q, hold_d;
   logic              lane_q, lane_d, valid_q, valid_d;
   logic              clr_prev_q, clr_prev_d, done_prev_q, done_prev_d;
   logic              done_seen_q, done_seen_d, drain_q, drain_d;
   logic              overflow_q, overflow_d;

   logic [PW-1:0]     pair_in, head, head_nxt, nxt_pair;
   logic [CW-1:0]     fifo_cnt, cnt_after;
   logic              fifo_full, fifo_empty;
   logic              both_clr, cap, hs, pop, push, drop, drain_now;

   assign pair_in   = {acc_1_i, acc_0_i};
   assign both_clr  = clear_local_0_i & clear_local_1_i;
   assign cap       = both_clr & ~clr_prev_q;
   assign hs        = valid_q & res_ready_i;
   assign pop       = hs & (state_q == LANE1);
   assign push      = cap & (~fifo_full | pop);
   assign drop      = cap & fifo_full & ~pop;
   assign cnt_after = fifo_cnt + CW'(push) - CW'(pop);
   // With only the outgoing pair queued, the next head is whatever is being pushed right now.
   assign nxt_pair  = (fifo_cnt > CW'(1)) ? head_nxt : pair_in;
   assign drain_now = done_seen_q & fifo_empty & (state_q == IDLE) & ~cap;

   pair_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .push_i     (push),
      .pop_i      (pop),
      .wdata_i    (pair_in),
      .head_o     (head),
      .head_nxt_o (head_nxt),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      hold_d      = hold_q;
      lane_d      = lane_q;
      valid_d     = valid_q;
      clr_prev_d  = both_clr;
      done_prev_d = done_i;
      overflow_d  = overflow_q | drop;
      drain_d     = drain_now;
      done_seen_d = (done_seen_q & ~drain_now) | (done_i & ~done_prev_q);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               hold_d  = head[PW-1:DATA_W];
               data_d  = head[DATA_W-1:0];
               lane_d  = 1'b0;
               valid_d = 1'b1;
               state_d = LANE0;
            end
         end
         LANE0: begin
            if (hs) begin
               data_d  = hold_q;
               lane_d  = 1'b1;
               state_d = LANE1;
            end
         end
         LANE1: begin
            if (hs) begin
               if (cnt_after != '0) begin
                  hold_d  = nxt_pair[PW-1:DATA_W];
                  data_d  = nxt_pair[DATA_W-1:0];
                  lane_d  = 1'b0;
                  state_d = LANE0;
               end else begin
                  valid_d = 1'b0;
                  lane_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         data_q      <= '0;
         hold_q      <= '0;
         lane_q      <= 1'b0;
         valid_q     <= 1'b0;
         clr_prev_q  <= 1'b0;
         done_prev_q <= 1'b0;
         done_seen_q <= 1'b0;
         drain_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         hold_q      <= hold_d;
         lane_q      <= lane_d;
         valid_q     <= valid_d;
         clr_prev_q  <= clr_prev_d;
         done_prev_q <= done_prev_d;
         done_seen_q <= done_seen_d;
         drain_q     <= drain_d;
         overflow_q  <= overflow_d;
      end
   end

   assign res_data_o   = data_q;
   assign res_lane_o   = lane_q;
   assign res_valid_o  = valid_q;
   assign overflow_o   = overflow_q;
   assign drain_done_o = drain_q;
   assign busy_o       = ~fifo_empty | (state_q != IDLE);

endmodule
